hazard_ctrl_param: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB). It drives the operand-forwarding selects and the per-stage stall/flush vectors. Relative to the previous generation it adds:
- parametrised register-index width and mul/div tail length;
- explicit CP0-write flags instead of index-bit decoding;
- exceptions that arrive while a cache is busy are latched and replayed, not dropped;
- saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_param.sv | 192 +++++++++++++++++++
 tb/tb_hazard_ctrl_param.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_param.sv
// Hazard controller for the 5-stage MIPS pipeline: operand forwarding selects, per-stage
// stall/flush vectors, replay of exceptions raised during cache activity, perf counters.
module hazard_ctrl_param #(
  parameter int REG_W   = 7,
  parameter int MD_TAIL = 2,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_req,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              alu_busy,
  input  logic              alu_done,
  input  logic              branch_d,
  input  logic [REG_W-1:0]  rs_d,
  input  logic [REG_W-1:0]  rt_d,
  input  logic [REG_W-1:0]  rs_e,
  input  logic [REG_W-1:0]  rt_e,
  input  logic [REG_W-1:0]  wr_e,
  input  logic [REG_W-1:0]  wr_m,
  input  logic [REG_W-1:0]  wr_w,
  input  logic              regwr_e,
  input  logic              regwr_m,
  input  logic              regwr_w,
  input  logic              memrd_m,
  input  logic              memtoreg_m,
  input  logic              cp0wr_e,
  input  logic              cp0wr_m,
  input  logic              cp0wr_w,
  output logic [4:0]        stall,
  output logic [3:0]        flush,
  output logic [1:0]        fwd_a_d,
  output logic [1:0]        fwd_b_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic [3:0]        state,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  localparam logic [3:0] S_RUN       = 4'b0000;
  localparam logic [3:0] S_EXC_FLUSH = 4'b0001;
  localparam logic [3:0] S_ALU_WAIT  = 4'b0011;
  localparam logic [3:0] S_LOAD_USE  = 4'b0100;
  localparam logic [3:0] S_CP0_M     = 4'b1000;
  localparam logic [3:0] S_MD_TAIL   = 4'b1001;
  localparam logic [3:0] S_BR_EX     = 4'b1010;
  localparam logic [3:0] S_CP0_E     = 4'b1011;
  localparam logic [3:0] S_IF_WAIT   = 4'b1100;
  localparam logic [3:0] S_MEM_WAIT  = 4'b1101;
  localparam logic [3:0] S_EXC_HOLD  = 4'b1110;
  localparam logic [3:0] S_CP0_W     = 4'b1111;
  localparam int TW = (MD_TAIL > 0) ? $clog2(MD_TAIL + 1) : 1;

  logic [3:0]        r_state;
  logic [3:0]        w_next_state;
  logic              r_exc_pend;
  logic [TW-1:0]     r_tail_cnt;
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;
  logic              w_exc;
  logic              w_load_use;
  logic              w_br_ex;
  logic              w_tail_load;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             rw_m,
    input logic             m2r_m,
    input logic [REG_W-1:0] w_m,
    input logic             rw_w,
    input logic [REG_W-1:0] w_w
  );
    logic [1:0] sel;
    if (src == '0)
      sel = 2'b00;
    else if (rw_m && !m2r_m && (w_m == src))
      sel = 2'b10;
    else if (rw_w && (w_w == src))
      sel = 2'b01;
    else
      sel = 2'b00;
    return sel;
  endfunction

  assign fwd_a_d = rst ? fwd_sel(rs_d, regwr_m, memtoreg_m, wr_m, regwr_w, wr_w) : 2'b00;
  assign fwd_b_d = rst ? fwd_sel(rt_d, regwr_m, memtoreg_m, wr_m, regwr_w, wr_w) : 2'b00;
  assign fwd_a_e = rst ? fwd_sel(rs_e, regwr_m, memtoreg_m, wr_m, regwr_w, wr_w) : 2'b00;
  assign fwd_b_e = rst ? fwd_sel(rt_e, regwr_m, memtoreg_m, wr_m, regwr_w, wr_w) : 2'b00;

  assign w_exc      = exc_req | r_exc_pend;
  assign w_load_use = memrd_m && regwr_m && (wr_m != '0) &&
                      ((wr_m == rs_e) || (wr_m == rt_e) ||
                       (branch_d && ((wr_m == rs_d) || (wr_m == rt_d))));
  assign w_br_ex    = branch_d && regwr_e && (wr_e != '0) && ((wr_e == rs_d) || (wr_e == rt_d));
  // Tail starts when mul/div leaves ALU_WAIT normally; an exception cancels it instead.
  assign w_tail_load = (r_state == S_ALU_WAIT) && (w_next_state != S_ALU_WAIT) &&
                       (w_next_state != S_EXC_HOLD) && (w_next_state != S_EXC_FLUSH);
  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_RUN;
    else
      r_state <= w_next_state;
  end

  // Next-state priority decision
  always_comb begin
    w_next_state = S_RUN;
    if (w_exc && (if_busy || mem_busy))  w_next_state = S_EXC_HOLD;
    else if (w_exc)                      w_next_state = S_EXC_FLUSH;
    else if (cp0wr_w)                    w_next_state = S_CP0_W;
    else if (mem_busy)                   w_next_state = S_MEM_WAIT;
    else if (w_load_use)                 w_next_state = S_LOAD_USE;
    else if (alu_busy && !alu_done)      w_next_state = S_ALU_WAIT;
    else if (cp0wr_m)                    w_next_state = S_CP0_M;
    else if (r_tail_cnt != '0)           w_next_state = S_MD_TAIL;
    else if (if_busy)                    w_next_state = S_IF_WAIT;
    else if (w_br_ex)                    w_next_state = S_BR_EX;
    else if (cp0wr_e)                    w_next_state = S_CP0_E;
    else                                 w_next_state = S_RUN;
  end

  // Stall/flush pattern of the decided state, forced quiet while in reset
  always_comb begin
    stall = 5'b00000;
    flush = 4'b0000;
    if (!rst) begin
      stall = 5'b00000;
      flush = 4'b0000;
    end else begin
      case (w_next_state)
        S_EXC_HOLD:  begin stall = 5'b11111; flush = 4'b0000; end
        S_EXC_FLUSH: begin stall = 5'b11111; flush = 4'b1111; end
        S_CP0_W:     begin stall = 5'b11110; flush = 4'b0001; end
        S_MEM_WAIT:  begin stall = 5'b11111; flush = 4'b0001; end
        S_LOAD_USE:  begin stall = 5'b11100; flush = 4'b0010; end
        S_ALU_WAIT:  begin stall = 5'b11111; flush = 4'b0001; end
        S_CP0_M, S_MD_TAIL, S_IF_WAIT, S_BR_EX, S_CP0_E:
                     begin stall = 5'b11000; flush = 4'b0100; end
        default:     begin stall = 5'b00000; flush = 4'b0000; end
      endcase
    end
  end

  // Pending-exception latch and mul/div tail counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exc_pend <= 1'b0;
      r_tail_cnt <= '0;
    end else begin
      if (w_next_state == S_EXC_HOLD)
        r_exc_pend <= 1'b1;
      else if (w_next_state == S_EXC_FLUSH)
        r_exc_pend <= 1'b0;
      else
        r_exc_pend <= r_exc_pend;

      if (w_next_state == S_EXC_FLUSH)
        r_tail_cnt <= '0;
      else if (w_tail_load)
        r_tail_cnt <= TW'(MD_TAIL);
      else if (w_next_state == S_MD_TAIL)
        r_tail_cnt <= r_tail_cnt - TW'(1);
      else
        r_tail_cnt <= r_tail_cnt;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall[4] && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      else
        r_stall_cnt <= r_stall_cnt;
      if ((flush != 4'b0000) && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + PERF_W'(1);
      else
        r_flush_cnt <= r_flush_cnt;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Self-checking bench for hazard_ctrl_param: forwarding vector table, hand-written
// multi-cycle sequences, and randomized traffic against a rule-table reference model.
module tb_hazard_ctrl_param;

  localparam int MDT  = 2;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst;
  logic exc_req, if_busy, mem_busy, alu_busy, alu_done, branch_d;
  logic [6:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic regwr_e, regwr_m, regwr_w, memrd_m, memtoreg_m, cp0wr_e, cp0wr_m, cp0wr_w;
  logic [4:0] stall;
  logic [3:0] flush;
  logic [1:0] fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
  logic [3:0] state;
  logic [3:0] stall_cnt, flush_cnt;

  hazard_ctrl_param #(.REG_W(7), .MD_TAIL(MDT), .PERF_W(4)) dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .if_busy(if_busy), .mem_busy(mem_busy),
    .alu_busy(alu_busy), .alu_done(alu_done), .branch_d(branch_d),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .wr_e(wr_e), .wr_m(wr_m), .wr_w(wr_w),
    .regwr_e(regwr_e), .regwr_m(regwr_m), .regwr_w(regwr_w),
    .memrd_m(memrd_m), .memtoreg_m(memtoreg_m),
    .cp0wr_e(cp0wr_e), .cp0wr_m(cp0wr_m), .cp0wr_w(cp0wr_w),
    .stall(stall), .flush(flush),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Priority rules in order: resulting state code, stall vector, flush vector
  localparam logic [3:0] R_CODE  [12] = '{4'b1110, 4'b0001, 4'b1111, 4'b1101, 4'b0100, 4'b0011,
                                          4'b1000, 4'b1001, 4'b1100, 4'b1010, 4'b1011, 4'b0000};
  localparam logic [4:0] R_STALL [12] = '{5'b11111, 5'b11111, 5'b11110, 5'b11111, 5'b11100, 5'b11111,
                                          5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b00000};
  localparam logic [3:0] R_FLUSH [12] = '{4'b0000, 4'b1111, 4'b0001, 4'b0001, 4'b0010, 4'b0001,
                                          4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};

  logic [3:0] m_state;
  bit         m_pend;
  int         m_tail, m_scnt, m_fcnt;
  int         g_rule;
  int         n_pass = 0;
  int         n_total = 0;

  typedef struct {
    logic [6:0] src;
    logic [6:0] wm;
    logic       rm;
    logic       mtr;
    logic [6:0] ww;
    logic       rw;
    logic [1:0] exp;
  } fvec_t;
  fvec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int decide();
    bit exc, lu, bre;
    bit c [12];
    exc = exc_req || m_pend;
    lu  = memrd_m && regwr_m && (wr_m != 0) &&
          ((wr_m == rs_e) || (wr_m == rt_e) || (branch_d && ((wr_m == rs_d) || (wr_m == rt_d))));
    bre = branch_d && regwr_e && (wr_e != 0) && ((wr_e == rs_d) || (wr_e == rt_d));
    c = '{exc && (if_busy || mem_busy), exc, cp0wr_w, mem_busy, lu, alu_busy && !alu_done,
          cp0wr_m, m_tail != 0, if_busy, bre, cp0wr_e, 1'b1};
    for (int i = 0; i < 12; i++)
      if (c[i]) return i;
    return 11;
  endfunction

  function automatic int mfwd(input int src);
    if (src == 0) return 0;
    if (regwr_m && !memtoreg_m && (int'(wr_m) == src)) return 2;
    if (regwr_w && (int'(wr_w) == src)) return 1;
    return 0;
  endfunction

  task automatic mreset();
    m_state = 4'b0000; m_pend = 1'b0; m_tail = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic mstep(input int r);
    logic [4:0] st;
    logic [3:0] fl;
    int nt;
    nt = m_tail;
    if (r == 1) nt = 0;
    else if ((m_state == 4'b0011) && (r != 0) && (r != 5)) nt = MDT;
    else if (r == 7) nt = m_tail - 1;
    if (r == 0) m_pend = 1'b1;
    else if (r == 1) m_pend = 1'b0;
    st = R_STALL[r];
    fl = R_FLUSH[r];
    if (st[4] && (m_scnt < CMAX)) m_scnt++;
    if ((fl != 4'b0000) && (m_fcnt < CMAX)) m_fcnt++;
    m_tail  = nt;
    m_state = R_CODE[r];
  endtask

  task automatic clear_inputs();
    exc_req = 0; if_busy = 0; mem_busy = 0; alu_busy = 0; alu_done = 0; branch_d = 0;
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; wr_e = 0; wr_m = 0; wr_w = 0;
    regwr_e = 0; regwr_m = 0; regwr_w = 0; memrd_m = 0; memtoreg_m = 0;
    cp0wr_e = 0; cp0wr_m = 0; cp0wr_w = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    g_rule = decide();
    if (!rst) begin
      chk("stall", stall, 0); chk("flush", flush, 0);
      chk("fwd_a_d", fwd_a_d, 0); chk("fwd_b_d", fwd_b_d, 0);
      chk("fwd_a_e", fwd_a_e, 0); chk("fwd_b_e", fwd_b_e, 0);
    end else begin
      chk("stall", stall, R_STALL[g_rule]); chk("flush", flush, R_FLUSH[g_rule]);
      chk("fwd_a_d", fwd_a_d, mfwd(rs_d)); chk("fwd_b_d", fwd_b_d, mfwd(rt_d));
      chk("fwd_a_e", fwd_a_e, mfwd(rs_e)); chk("fwd_b_e", fwd_b_e, mfwd(rt_e));
    end
    chk("state", state, m_state);
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", flush_cnt, m_fcnt);
  endtask

  task automatic advance();
    if (rst) mstep(g_rule);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    mreset();
    sample();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    tbl[0] = '{7'd5,   7'd5,   1'b1, 1'b0, 7'd5, 1'b1, 2'b10};
    tbl[1] = '{7'd0,   7'd0,   1'b1, 1'b0, 7'd0, 1'b1, 2'b00};
    tbl[2] = '{7'd5,   7'd5,   1'b1, 1'b1, 7'd5, 1'b1, 2'b01};
    tbl[3] = '{7'd5,   7'd6,   1'b1, 1'b0, 7'd5, 1'b1, 2'b01};
    tbl[4] = '{7'd5,   7'd5,   1'b0, 1'b0, 7'd5, 1'b0, 2'b00};
    tbl[5] = '{7'd127, 7'd127, 1'b1, 1'b0, 7'd3, 1'b1, 2'b10};
    tbl[6] = '{7'd9,   7'd3,   1'b1, 1'b0, 7'd9, 1'b0, 2'b00};
    tbl[7] = '{7'd0,   7'd0,   1'b1, 1'b0, 7'd7, 1'b1, 2'b00};

    do_reset();

    // Forwarding vector table
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      rs_d = tbl[i].src; rt_d = tbl[i].src; rs_e = tbl[i].src; rt_e = tbl[i].src;
      wr_m = tbl[i].wm; regwr_m = tbl[i].rm; memtoreg_m = tbl[i].mtr;
      wr_w = tbl[i].ww; regwr_w = tbl[i].rw;
      sample();
      chk("tbl_fwd_a_e", fwd_a_e, tbl[i].exp);
      chk("tbl_fwd_b_d", fwd_b_d, tbl[i].exp);
      chk("tbl_stall", stall, 0);
      advance();
    end

    // Load-use
    do_reset();
    memrd_m = 1; regwr_m = 1; wr_m = 7'd3; rt_e = 7'd3;
    sample();
    chk("lu_stall", stall, 5'b11100);
    chk("lu_flush", flush, 4'b0010);
    advance();
    clear_inputs();
    sample();
    chk("lu_state", state, 4'b0100);
    chk("lu_stall_cnt", stall_cnt, 1);
    advance();

    // Mul/div with tail
    do_reset();
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      if (i < 5) alu_busy = 1;
      if (i == 4) alu_done = 1;
      sample();
      if (i < 4) begin
        chk("md_busy_stall", stall, 5'b11111); chk("md_busy_flush", flush, 4'b0001);
      end else if (i == 5 || i == 6) begin
        chk("md_tail_stall", stall, 5'b11000); chk("md_tail_flush", flush, 4'b0100);
      end else begin
        chk("md_run_stall", stall, 5'b00000);
      end
      advance();
    end

    // Exception during D-side busy
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      mem_busy = (i < 3);
      exc_req  = (i == 0);
      sample();
      if (i < 3) begin
        chk("exc_hold_stall", stall, 5'b11111); chk("exc_hold_flush", flush, 4'b0000);
      end else if (i == 3) begin
        chk("exc_flush_stall", stall, 5'b11111); chk("exc_flush_flush", flush, 4'b1111);
      end else begin
        chk("exc_run_flush", flush, 4'b0000); chk("exc_flush_cnt", flush_cnt, 1);
      end
      advance();
    end

    // Priority of CP0 write in WB over D-side busy
    clear_inputs();
    cp0wr_w = 1; mem_busy = 1;
    sample();
    chk("prio_cp0w_stall", stall, 5'b11110);
    chk("prio_cp0w_flush", flush, 4'b0001);
    advance();
    cp0wr_w = 0;
    sample();
    chk("prio_mem_stall", stall, 5'b11111);
    advance();
    sample();
    chk("prio_mem_state", state, 4'b1101);
    advance();

    // Counter saturation
    do_reset();
    mem_busy = 1;
    for (int i = 0; i < 20; i++) begin
      sample();
      advance();
    end
    clear_inputs();
    sample();
    chk("sat_stall_cnt", stall_cnt, 15);
    chk("sat_flush_cnt", flush_cnt, 15);
    advance();

    // Asynchronous reset in the middle of EXC_HOLD
    do_reset();
    mem_busy = 1; exc_req = 1;
    sample();
    advance();
    exc_req = 0;
    sample();
    advance();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_flush", flush, 0);
    chk("arst_state", state, 0);
    mreset();
    @(posedge clk);
    #1;
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("arst_after_flush", flush, 0);
      advance();
    end

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      exc_req  = ($urandom_range(0, 15) == 0);
      if_busy  = ($urandom_range(0, 5) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      alu_busy = ($urandom_range(0, 2) == 0);
      alu_done = ($urandom_range(0, 2) == 0);
      branch_d = ($urandom_range(0, 2) == 0);
      rs_d = 7'($urandom_range(0, 7)); rt_d = 7'($urandom_range(0, 7));
      rs_e = 7'($urandom_range(0, 7)); rt_e = 7'($urandom_range(0, 7));
      wr_e = 7'($urandom_range(0, 7)); wr_m = 7'($urandom_range(0, 7));
      wr_w = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
      regwr_e = 1'($urandom_range(0, 1)); regwr_m = 1'($urandom_range(0, 1));
      regwr_w = 1'($urandom_range(0, 1));
      memrd_m = ($urandom_range(0, 2) == 0); memtoreg_m = ($urandom_range(0, 2) == 0);
      cp0wr_e = ($urandom_range(0, 9) == 0); cp0wr_m = ($urandom_range(0, 9) == 0);
      cp0wr_w = ($urandom_range(0, 9) == 0);
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
